// File: rtl/tpu_layer_sequencer.sv
// tpu_layer_sequencer
// Handshaked control sequencer for top_soc. It runs num_tiles tiles back-to-back.
// Each tile goes through a weight FIFO fill, a drain into the array, a multiply
// and a wait for output_done. The memory bases advance by addr_stride per tile,
// and the current bases are replicated onto every lane.
module tpu_layer_sequencer #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ADDR_W       = 8,
    parameter int TILE_W       = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [TILE_W-1:0]              num_tiles,
    input  logic [ADDR_W-1:0]              weight_base,
    input  logic [ADDR_W-1:0]              input_base,
    input  logic [ADDR_W-1:0]              output_base,
    input  logic [ADDR_W-1:0]              addr_stride,
    input  logic                           mem_to_fifo_done,
    input  logic                           fifo_to_arr_done,
    input  logic                           output_done,
    output logic                           fill_fifo,
    output logic                           drain_fifo,
    output logic                           active,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] weightMem_rd_addr_base,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] inputMem_rd_addr_base,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] outputMem_wr_addr_base,
    output logic [TILE_W-1:0]              tile_idx,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_WAIT_FILL,
        S_DRAIN,
        S_COMPUTE,
        S_WAIT_OUT,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TILE_W-1:0]   num_q, num_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [ADDR_W-1:0]   wbase_q, wbase_d;
    logic [ADDR_W-1:0]   ibase_q, ibase_d;
    logic [ADDR_W-1:0]   obase_q, obase_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic                error_q, error_d;
    logic                timed_out;

    // Last permitted wait cycle: the counter starts at 0 on entry, so TIMEOUT cycles have elapsed here
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state, run parameter capture, per-tile base advance and wait-state timeout counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        num_d    = num_q;
        tile_d   = tile_q;
        wbase_d  = wbase_q;
        ibase_d  = ibase_q;
        obase_d  = obase_q;
        stride_d = stride_q;
        error_d  = error_q;

        if (abort) begin
            // abort overrides start and every done input, and it leaves error untouched
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        num_d    = num_tiles;
                        wbase_d  = weight_base;
                        ibase_d  = input_base;
                        obase_d  = output_base;
                        stride_d = addr_stride;
                        tile_d   = '0;
                        error_d  = 1'b0;
                        state_d  = (num_tiles == '0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: state_d = S_WAIT_FILL;
                S_WAIT_FILL: begin
                    if (mem_to_fifo_done) begin
                        state_d = S_DRAIN;
                    end else if (timed_out) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (fifo_to_arr_done) begin
                        state_d = S_COMPUTE;
                    end else if (timed_out) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_COMPUTE: state_d = S_WAIT_OUT;
                S_WAIT_OUT: begin
                    if (output_done) begin
                        state_d = S_NEXT;
                    end else if (timed_out) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (tile_q == num_q - TILE_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        tile_d  = tile_q + TILE_W'(1);
                        wbase_d = wbase_q + stride_q;
                        ibase_d = ibase_q + stride_q;
                        obase_d = obase_q + stride_q;
                        state_d = S_FILL;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            num_q    <= '0;
            tile_q   <= '0;
            wbase_q  <= '0;
            ibase_q  <= '0;
            obase_q  <= '0;
            stride_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            tile_q   <= tile_d;
            wbase_q  <= wbase_d;
            ibase_q  <= ibase_d;
            obase_q  <= obase_d;
            stride_q <= stride_d;
            error_q  <= error_d;
        end
    end

    assign fill_fifo              = (state_q == S_FILL);
    assign drain_fifo             = (state_q == S_DRAIN);
    assign active                 = (state_q == S_COMPUTE);
    assign done                   = (state_q == S_DONE);
    assign busy                   = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign error                  = error_q;
    assign tile_idx               = tile_q;
    assign weightMem_rd_addr_base = {WIDTH_HEIGHT{wbase_q}};
    assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{ibase_q}};
    assign outputMem_wr_addr_base = {WIDTH_HEIGHT{obase_q}};

endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// Self-checking bench for tpu_layer_sequencer.
// Each job is turned into a cycle schedule built from per-tile handshake delays.
// The schedule holds the expected strobes, tile index and bases for every cycle,
// together with the done inputs that a top_soc model drives.
module tb_tpu_layer_sequencer;

    localparam int WH   = 16;
    localparam int AW   = 8;
    localparam int TW   = 8;
    localparam int TO   = 64;
    localparam int MAXC = 512;

    logic               clk = 1'b0;
    logic               reset, start, abort;
    logic [TW-1:0]      num_tiles;
    logic [AW-1:0]      weight_base, input_base, output_base, addr_stride;
    logic               mem_to_fifo_done, fifo_to_arr_done, output_done;
    logic               fill_fifo, drain_fifo, active, busy, done, error;
    logic [WH*AW-1:0]   w_bus, i_bus, o_bus;
    logic [TW-1:0]      tile_idx;

    int n_cmp = 0;
    int n_err = 0;

    // Per-cycle schedule of the current job (cycle 0 is the start cycle)
    bit            e_fill [MAXC];
    bit            e_drain[MAXC];
    bit            e_act  [MAXC];
    bit            e_done [MAXC];
    bit            e_busy [MAXC];
    logic [TW-1:0] e_tile [MAXC];
    logic [AW-1:0] e_wb   [MAXC];
    logic [AW-1:0] e_ib   [MAXC];
    logic [AW-1:0] e_ob   [MAXC];
    bit            i_mfd  [MAXC];
    bit            i_fad  [MAXC];
    bit            i_od   [MAXC];

    always #5 clk = ~clk;

    tpu_layer_sequencer #(
        .WIDTH_HEIGHT(WH),
        .ADDR_W(AW),
        .TILE_W(TW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .num_tiles(num_tiles),
        .weight_base(weight_base),
        .input_base(input_base),
        .output_base(output_base),
        .addr_stride(addr_stride),
        .mem_to_fifo_done(mem_to_fifo_done),
        .fifo_to_arr_done(fifo_to_arr_done),
        .output_done(output_done),
        .fill_fifo(fill_fifo),
        .drain_fifo(drain_fifo),
        .active(active),
        .weightMem_rd_addr_base(w_bus),
        .inputMem_rd_addr_base(i_bus),
        .outputMem_wr_addr_base(o_bus),
        .tile_idx(tile_idx),
        .busy(busy),
        .done(done),
        .error(error)
    );

    function automatic logic [WH*AW-1:0] rep(input logic [AW-1:0] b);
        return {WH{b}};
    endfunction

    // Runs one job. A fixd >= 0 gives every handshake that delay; otherwise each delay is random in 0..dmax.
    // A delay d means that the done input rises d cycles after the stage strobe.
    task automatic run_job(input string tag, input int nt, input logic [AW-1:0] bw, input logic [AW-1:0] bi,
                           input logic [AW-1:0] bo, input logic [AW-1:0] bs, input int dmax, input int fixd);
        int f, d1, d2, d3, w1, w3, dr0, dr1, c, nx, done_t, end_t;
        logic [AW-1:0] cw, ci, co;
        for (int t = 0; t < MAXC; t++) begin
            e_fill[t] = 0; e_drain[t] = 0; e_act[t] = 0; e_done[t] = 0; e_busy[t] = 0;
            e_tile[t] = '0; e_wb[t] = '0; e_ib[t] = '0; e_ob[t] = '0;
            i_mfd[t] = 0; i_fad[t] = 0; i_od[t] = 0;
        end
        cw = bw; ci = bi; co = bo;
        f = 1;
        done_t = 1;
        for (int k = 0; k < nt; k++) begin
            d1 = (fixd >= 0) ? fixd : int'($urandom_range(dmax, 0));
            d2 = (fixd >= 0) ? fixd : int'($urandom_range(dmax, 0));
            d3 = (fixd >= 0) ? fixd : int'($urandom_range(dmax, 0));
            w1 = (d1 == 0) ? 1 : d1;
            w3 = (d3 == 0) ? 1 : d3;
            dr0 = f + w1 + 1;
            dr1 = dr0 + d2;
            c   = dr1 + 1;
            nx  = c + w3 + 1;
            e_fill[f] = 1;
            for (int t = dr0; t <= dr1; t++) e_drain[t] = 1;
            e_act[c] = 1;
            for (int t = f; t <= nx; t++) begin
                e_busy[t] = 1; e_tile[t] = TW'(k); e_wb[t] = cw; e_ib[t] = ci; e_ob[t] = co;
            end
            for (int t = f + d1; t <= f + w1; t++) i_mfd[t] = 1;
            i_fad[dr1] = 1;
            for (int t = c + d3; t <= c + w3; t++) i_od[t] = 1;
            done_t = nx + 1;
            if (k < nt - 1) begin
                f = nx + 1;
                cw = cw + bs; ci = ci + bs; co = co + bs;
            end
        end
        end_t = done_t + 2;
        if (end_t >= MAXC) begin
            $display("FAIL %s schedule too long (%0d cycles, limit %0d)", tag, end_t, MAXC);
            $fatal(1);
        end
        e_done[done_t] = 1;
        for (int t = done_t; t <= end_t; t++) begin
            e_tile[t] = (nt == 0) ? '0 : TW'(nt - 1);
            e_wb[t] = cw; e_ib[t] = ci; e_ob[t] = co;
        end

        for (int t = 0; t <= end_t; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                n_cmp++; if (fill_fifo !== e_fill[t]) begin n_err++; $display("FAIL %s fill_fifo t=%0d got %b exp %b", tag, t, fill_fifo, e_fill[t]); end
                n_cmp++; if (drain_fifo !== e_drain[t]) begin n_err++; $display("FAIL %s drain_fifo t=%0d got %b exp %b", tag, t, drain_fifo, e_drain[t]); end
                n_cmp++; if (active !== e_act[t]) begin n_err++; $display("FAIL %s active t=%0d got %b exp %b", tag, t, active, e_act[t]); end
                n_cmp++; if (done !== e_done[t]) begin n_err++; $display("FAIL %s done t=%0d got %b exp %b", tag, t, done, e_done[t]); end
                n_cmp++; if (busy !== e_busy[t]) begin n_err++; $display("FAIL %s busy t=%0d got %b exp %b", tag, t, busy, e_busy[t]); end
                n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL %s error t=%0d got %b exp 0", tag, t, error); end
                n_cmp++; if (tile_idx !== e_tile[t]) begin n_err++; $display("FAIL %s tile_idx t=%0d got %0d exp %0d", tag, t, tile_idx, e_tile[t]); end
                n_cmp++; if (w_bus !== rep(e_wb[t])) begin n_err++; $display("FAIL %s weight_bus t=%0d got %h exp %h", tag, t, w_bus, rep(e_wb[t])); end
                n_cmp++; if (i_bus !== rep(e_ib[t])) begin n_err++; $display("FAIL %s input_bus t=%0d got %h exp %h", tag, t, i_bus, rep(e_ib[t])); end
                n_cmp++; if (o_bus !== rep(e_ob[t])) begin n_err++; $display("FAIL %s output_bus t=%0d got %h exp %h", tag, t, o_bus, rep(e_ob[t])); end
            end
            start = (t == 0);
            if (t == 0) begin
                num_tiles = TW'(nt); weight_base = bw; input_base = bi; output_base = bo; addr_stride = bs;
            end else begin
                // Scramble the run inputs after start to prove that they were captured
                num_tiles = TW'($urandom); weight_base = AW'($urandom); input_base = AW'($urandom);
                output_base = AW'($urandom); addr_stride = AW'($urandom);
            end
            mem_to_fifo_done = i_mfd[t];
            fifo_to_arr_done = i_fad[t];
            output_done      = i_od[t];
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({fill_fifo, drain_fifo, active, busy, done, error} !== 6'b0) begin n_err++; $display("FAIL reset_strobes got %b exp 000000", {fill_fifo, drain_fifo, active, busy, done, error}); end
        n_cmp++; if (tile_idx !== '0) begin n_err++; $display("FAIL reset_tile got %0d exp 0", tile_idx); end
        n_cmp++; if ({w_bus, i_bus, o_bus} !== '0) begin n_err++; $display("FAIL reset_buses got %h exp 0", {w_bus, i_bus, o_bus}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        run_job("single", 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16);
    endtask

    task automatic test_multi();
        run_job("multi", 3, 8'h20, 8'h20, 8'h20, 8'h10, 4, -1);
    endtask

    task automatic test_wrap();
        run_job("wrap", 2, 8'hF0, 8'hF0, 8'hF0, 8'h20, 3, -1);
    endtask

    task automatic test_zero_tiles();
        run_job("zero", 0, 8'h5A, 8'h33, 8'hC1, 8'h07, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 8; j++)
            run_job("random", int'($urandom_range(4, 1)), AW'($urandom), AW'($urandom), AW'($urandom),
                    AW'($urandom), 5, -1);
    endtask

    // fifo_to_arr_done is withheld. mem_to_fifo_done is already high at start, so DRAIN spans cycles 3..66 and ERR begins at 67.
    task automatic test_timeout();
        bit exp_drain, exp_err, exp_busy, exp_fill;
        for (int t = 0; t <= 72; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                exp_fill  = (t == 1);
                exp_drain = (t >= 3 && t <= 66);
                exp_busy  = (t >= 1 && t <= 66);
                exp_err   = (t >= 67);
                n_cmp++; if (fill_fifo !== exp_fill) begin n_err++; $display("FAIL timeout fill_fifo t=%0d got %b exp %b", t, fill_fifo, exp_fill); end
                n_cmp++; if (drain_fifo !== exp_drain) begin n_err++; $display("FAIL timeout drain_fifo t=%0d got %b exp %b", t, drain_fifo, exp_drain); end
                n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL timeout busy t=%0d got %b exp %b", t, busy, exp_busy); end
                n_cmp++; if (error !== exp_err) begin n_err++; $display("FAIL timeout error t=%0d got %b exp %b", t, error, exp_err); end
                n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL timeout active t=%0d got %b exp 0", t, active); end
            end
            start = (t == 0);
            num_tiles = 8'd1; weight_base = 8'h11; input_base = 8'h22; output_base = 8'h33; addr_stride = 8'h01;
            mem_to_fifo_done = (t <= 68);
            fifo_to_arr_done = 1'b0;
            output_done = (t == 70);
        end
        mem_to_fifo_done = 1'b0;
        output_done = 1'b0;
        run_job("after_err", 2, 8'h40, 8'h50, 8'h60, 8'h08, 3, -1);
    endtask

    // Stops a job in WAIT_OUT, either through abort or through reset, and then injects stray dones and an abort+start pair
    task automatic test_abort(input bit use_reset);
        logic [AW-1:0] b;
        bit exp_busy, exp_fill, exp_drain, exp_act;
        logic [AW-1:0] exp_b;
        b = AW'($urandom_range(255, 1));
        for (int t = 0; t <= 16; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                exp_fill  = (t == 1);
                exp_drain = (t == 3);
                exp_act   = (t == 4);
                exp_busy  = (t <= 7);
                exp_b     = (use_reset && t >= 8) ? '0 : b;
                n_cmp++; if (fill_fifo !== exp_fill) begin n_err++; $display("FAIL abort%0d fill_fifo t=%0d got %b exp %b", use_reset, t, fill_fifo, exp_fill); end
                n_cmp++; if (drain_fifo !== exp_drain) begin n_err++; $display("FAIL abort%0d drain_fifo t=%0d got %b exp %b", use_reset, t, drain_fifo, exp_drain); end
                n_cmp++; if (active !== exp_act) begin n_err++; $display("FAIL abort%0d active t=%0d got %b exp %b", use_reset, t, active, exp_act); end
                n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL abort%0d busy t=%0d got %b exp %b", use_reset, t, busy, exp_busy); end
                n_cmp++; if ({done, error} !== 2'b00) begin n_err++; $display("FAIL abort%0d done_error t=%0d got %b exp 00", use_reset, t, {done, error}); end
                n_cmp++; if (w_bus !== rep(exp_b)) begin n_err++; $display("FAIL abort%0d weight_bus t=%0d got %h exp %h", use_reset, t, w_bus, rep(exp_b)); end
                n_cmp++; if (tile_idx !== '0) begin n_err++; $display("FAIL abort%0d tile_idx t=%0d got %0d exp 0", use_reset, t, tile_idx); end
            end
            start = (t == 0) || (t == 9);
            abort = (!use_reset && t == 7) || (t == 9);
            reset = !(use_reset && t == 7);
            num_tiles = 8'd2; weight_base = (t == 0) ? b : ~b; input_base = b; output_base = b; addr_stride = 8'h04;
            mem_to_fifo_done = (t == 1) || (t == 2) || (t == 12);
            fifo_to_arr_done = (t == 3) || (t == 13);
            output_done      = (t == 10) || (t == 11);
        end
        start = 1'b0; abort = 1'b0; reset = 1'b1;
        mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        num_tiles = '0; weight_base = '0; input_base = '0; output_base = '0; addr_stride = '0;
        mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_wrap();
        test_zero_tiles();
        test_back_to_back();
        test_timeout();
        test_abort(1'b0);
        test_abort(1'b1);
        test_multi();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
